// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin multi-port arbiter for an asynchronous SRAM
// IDLE -> (SETUP for writes) -> ACCESS x (WAIT_CYCLES+1) -> DONE; every SRAM pin is registered.
module sram_port_arbiter #(
  parameter int NPORTS      = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS-1:0]              req_i,
  input  logic [NPORTS-1:0]              we_i,
  input  logic [NPORTS*ADDR_W-1:0]       addr_i,
  input  logic [NPORTS*DATA_W-1:0]       wdata_i,
  input  logic [NPORTS*(DATA_W/8)-1:0]   be_n_i,
  output logic [NPORTS-1:0]              ack_o,
  output logic [NPORTS*DATA_W-1:0]       rdata_o,
  output logic [ADDR_W-1:0]              ram_addr_o,
  output logic [DATA_W/8-1:0]            ram_be_n_o,
  output logic                           ram_ce_n_o,
  output logic                           ram_oe_n_o,
  output logic                           ram_we_n_o,
  inout  wire  [DATA_W-1:0]              ram_data_io
);

  localparam int NBE = DATA_W / 8;
  localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int SW  = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d, sel;
  logic [SW-1:0]       idx;
  logic                grant, latch, we_q, we_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NBE-1:0]      be_n_q;
  logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, drive_q, drive_d;
  logic [NPORTS-1:0]   ack_q, ack_d;
  logic [NPORTS*DATA_W-1:0] rdata_q;

  // Scan from the highest offset down so the port closest to ptr wins.
  always_comb begin
    grant = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + SW'(i);
      if (idx >= SW'(NPORTS)) idx = idx - SW'(NPORTS);
      if (req_i[idx[PW-1:0]]) begin
        grant = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

  assign latch = (state_q == IDLE) && grant;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          gnt_d   = sel;
          ptr_d   = (sel == PW'(NPORTS - 1)) ? '0 : sel + PW'(1);
          we_d    = we_i[sel];
          state_d = we_i[sel] ? SETUP : ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin levels are computed for the state being entered, then registered.
  always_comb begin
    ce_n_d  = ~((state_d == SETUP) || (state_d == ACCESS));
    oe_n_d  = ~((state_d == ACCESS) && !we_d);
    we_n_d  = ~((state_d == ACCESS) && we_d);
    drive_d = we_d && (state_d != IDLE);
    ack_d   = '0;
    if (state_d == DONE) ack_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_n_q  <= '1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
      if (latch) begin
        addr_q  <= addr_i[sel*ADDR_W +: ADDR_W];
        wdata_q <= wdata_i[sel*DATA_W +: DATA_W];
        be_n_q  <= be_n_i[sel*NBE +: NBE];
      end
      if ((state_q == ACCESS) && (cnt_q == 4'd0) && !we_q)
        rdata_q[gnt_q*DATA_W +: DATA_W] <= ram_data_io;
    end
  end

  assign ram_data_io = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr_o  = addr_q;
  assign ram_be_n_o  = be_n_q;
  assign ram_ce_n_o  = ce_n_q;
  assign ram_oe_n_o  = oe_n_q;
  assign ram_we_n_o  = we_n_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
// Two DUTs: WAIT_CYCLES=1 with a behavioural SRAM, and WAIT_CYCLES=0 for the short-access case.
module tb_sram_port_arbiter;

  localparam int W  = 1;
  localparam int LR = W + 2;
  localparam int LW = W + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req, we;
  logic [39:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be_n;
  logic [1:0]  ack;
  logic [63:0] rdata;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  wire  [31:0] ram_data;

  logic [1:0]  req1, we1;
  logic [39:0] addr1;
  logic [63:0] wdata1;
  logic [7:0]  be_n1;
  logic [1:0]  ack1;
  logic [63:0] rdata1;
  logic [19:0] ram1_addr;
  logic [3:0]  ram1_be_n;
  logic        ram1_ce_n, ram1_oe_n, ram1_we_n;
  wire  [31:0] ram1_data;
  logic [31:0] val1;

  sram_port_arbiter #(.NPORTS(2), .ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(W)) u0 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .be_n_i(be_n), .ack_o(ack), .rdata_o(rdata), .ram_addr_o(ram_addr),
    .ram_be_n_o(ram_be_n), .ram_ce_n_o(ram_ce_n), .ram_oe_n_o(ram_oe_n),
    .ram_we_n_o(ram_we_n), .ram_data_io(ram_data));

  sram_port_arbiter #(.NPORTS(2), .ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .be_n_i(be_n1), .ack_o(ack1), .rdata_o(rdata1), .ram_addr_o(ram1_addr),
    .ram_be_n_o(ram1_be_n), .ram_ce_n_o(ram1_ce_n), .ram_oe_n_o(ram1_oe_n),
    .ram_we_n_o(ram1_we_n), .ram_data_io(ram1_data));

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] bn);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = bn[b] ? old[b*8 +: 8] : d[b*8 +: 8];
    return r;
  endfunction

  // Behavioural SRAM: reads are combinational, writes land on each strobed clock.
  logic [31:0] mem [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;
  assign ram_data  = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[5:0]] : 32'bz;
  assign ram1_data = (!ram1_ce_n && !ram1_oe_n) ? val1 : 32'bz;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!ram_ce_n && !ram_we_n)
      mem[ram_addr[5:0]] <= merge(mem[ram_addr[5:0]], ram_data, ram_be_n);
  end

  int cyc = 0, oe_low = 0, we_low = 0, ce_low = 0, dbl_ack = 0, oe1_low = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!ram_oe_n) oe_low <= oe_low + 1;
    if (!ram_we_n) we_low <= we_low + 1;
    if (!ram_ce_n) ce_low <= ce_low + 1;
    if (ack[0] && ack[1]) dbl_ack <= dbl_ack + 1;
    if (!ram1_oe_n) oe1_low <= oe1_low + 1;
  end

  int tests = 0, fails = 0;
  logic [31:0] m_mem [64];
  logic [31:0] m_rd [2];
  int m_ptr;

  task automatic preload(input int a, input logic [31:0] d);
    pre_addr = 6'(a); pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic pulse_reset();
    req = '0; req1 = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_ptr = 0; m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic run_txn(input int p, input bit w, input logic [19:0] a, input logic [31:0] d,
                         input logic [3:0] bn, output int lat, output int gotp);
    int start;
    we[p] = w; addr[p*20 +: 20] = a; wdata[p*32 +: 32] = d; be_n[p*4 +: 4] = bn;
    req[p] = 1'b1; start = cyc; lat = -1; gotp = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        lat = cyc - start; gotp = ack[1] ? 1 : 0; req[p] = 1'b0;
        break;
      end
    end
    req[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (ram_ce_n !== 1'b1) begin fails++; $display("FAIL reset_ce_n got %b want 1", ram_ce_n); end
    tests++; if (ram_oe_n !== 1'b1) begin fails++; $display("FAIL reset_oe_n got %b want 1", ram_oe_n); end
    tests++; if (ram_we_n !== 1'b1) begin fails++; $display("FAIL reset_we_n got %b want 1", ram_we_n); end
    tests++; if (ram_be_n !== 4'hF) begin fails++; $display("FAIL reset_be_n got %h want f", ram_be_n); end
    tests++; if (ram_addr !== 20'h0) begin fails++; $display("FAIL reset_addr got %h want 0", ram_addr); end
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL reset_ack got %b want 00", ack); end
    tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
    rst = 1'b1;
    @(negedge clk);
    m_ptr = 0; m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic test_read_basic();
    int lat, gp, o0;
    preload(16, 32'hDEADBEEF);
    o0 = oe_low;
    run_txn(0, 1'b0, 20'h00010, 32'h0, 4'h0, lat, gp);
    m_rd[0] = m_mem[16]; m_ptr = 1;
    tests++; if (lat != LR) begin fails++; $display("FAIL read_latency got %0d want %0d", lat, LR); end
    tests++; if (gp != 0) begin fails++; $display("FAIL read_ack_port got %0d want 0", gp); end
    tests++; if (oe_low - o0 != W + 1) begin fails++; $display("FAIL read_oe_cycles got %0d want %0d", oe_low - o0, W + 1); end
    tests++; if (rdata[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL read_data got %h want deadbeef", rdata[31:0]); end
  endtask

  task automatic test_write_basic();
    int lat, gp, w0, c0, o0;
    preload(32, 32'hAAAAAAAA);
    w0 = we_low; c0 = ce_low; o0 = oe_low;
    run_txn(1, 1'b1, 20'h00020, 32'h12345678, 4'b1100, lat, gp);
    m_mem[32] = 32'hAAAA5678; m_ptr = 0;
    tests++; if (lat != LW) begin fails++; $display("FAIL write_latency got %0d want %0d", lat, LW); end
    tests++; if (gp != 1) begin fails++; $display("FAIL write_ack_port got %0d want 1", gp); end
    tests++; if (we_low - w0 != W + 1) begin fails++; $display("FAIL write_we_cycles got %0d want %0d", we_low - w0, W + 1); end
    tests++; if (ce_low - c0 != W + 2) begin fails++; $display("FAIL write_ce_cycles got %0d want %0d", ce_low - c0, W + 2); end
    tests++; if (oe_low != o0) begin fails++; $display("FAIL write_oe_cycles got %0d want 0", oe_low - o0); end
    tests++; if (mem[32] !== 32'hAAAA5678) begin fails++; $display("FAIL write_mem got %h want aaaa5678", mem[32]); end
    tests++; if (rdata[63:32] !== m_rd[1]) begin fails++; $display("FAIL write_rdata_hold got %h want %h", rdata[63:32], m_rd[1]); end
    tests++; if (rdata[31:0] !== m_rd[0]) begin fails++; $display("FAIL write_rdata0_hold got %h want %h", rdata[31:0], m_rd[0]); end
  endtask

  task automatic test_round_robin();
    int got[$], at[$], exp_p, d0;
    pulse_reset();
    preload(3, $urandom); preload(5, $urandom);
    we = 2'b00; addr = {20'd5, 20'd3};
    d0 = dbl_ack;
    req = 2'b11;
    for (int n = 0; n < 60 && got.size() < 4; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (ack[k]) begin got.push_back(k); at.push_back(cyc); end
    end
    req = 2'b00;
    @(negedge clk);
    m_rd[0] = m_mem[3]; m_rd[1] = m_mem[5];
    tests++; if (got.size() != 4) begin fails++; $display("FAIL rr_ack_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      exp_p = m_ptr; m_ptr = (exp_p + 1) % 2;
      tests++; if (got[i] != exp_p) begin fails++; $display("FAIL rr_order[%0d] got %0d want %0d", i, got[i], exp_p); end
      if (i > 0) begin
        tests++;
        if (at[i] - at[i-1] != LR + 1) begin fails++; $display("FAIL rr_gap[%0d] got %0d want %0d", i, at[i] - at[i-1], LR + 1); end
      end
    end
    tests++; if (dbl_ack != d0) begin fails++; $display("FAIL rr_double_ack got %0d want 0", dbl_ack - d0); end
    tests++; if (rdata !== {m_rd[1], m_rd[0]}) begin fails++; $display("FAIL rr_rdata got %h want %h", rdata, {m_rd[1], m_rd[0]}); end
  endtask

  task automatic test_drop_req();
    int got[$], start, lat0;
    logic [31:0] d1;
    logic [3:0] b1;
    pulse_reset();
    preload(7, $urandom); preload(9, $urandom);
    d1 = $urandom; b1 = 4'($urandom);
    we = 2'b10; addr = {20'd9, 20'd7}; wdata = {d1, 32'h0}; be_n = {b1, 4'h0};
    req = 2'b11; start = cyc; lat0 = -1;
    repeat (2) @(negedge clk);
    req[0] = 1'b0; addr[19:0] = 20'd8; we[0] = 1'b1;
    for (int n = 0; n < 40 && got.size() < 2; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (ack[k]) begin
        got.push_back(k); req[k] = 1'b0;
        if (k == 0) lat0 = cyc - start;
      end
    end
    req = 2'b00;
    @(negedge clk);
    m_rd[0] = m_mem[7]; m_mem[9] = merge(m_mem[9], d1, b1); m_ptr = 0;
    tests++; if (got.size() != 2) begin fails++; $display("FAIL drop_ack_count got %0d want 2", got.size()); end
    tests++; if (got.size() > 0 && got[0] != 0) begin fails++; $display("FAIL drop_first got %0d want 0", got[0]); end
    tests++; if (lat0 != LR) begin fails++; $display("FAIL drop_latency got %0d want %0d", lat0, LR); end
    tests++; if (rdata[31:0] !== m_rd[0]) begin fails++; $display("FAIL drop_rdata got %h want %h", rdata[31:0], m_rd[0]); end
    tests++; if (mem[9] !== m_mem[9]) begin fails++; $display("FAIL drop_port1_write got %h want %h", mem[9], m_mem[9]); end
  endtask

  task automatic test_reset_mid_write();
    int got[$], seen;
    we = 2'b10; addr[39:20] = 20'd11; wdata[63:32] = $urandom; be_n[7:4] = 4'h0;
    req = 2'b10; seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (!ram_we_n) seen = 1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL rstmid_we_low got 0 want 1"); end
    #2 rst = 1'b0;
    #1;
    tests++; if (ram_we_n !== 1'b1) begin fails++; $display("FAIL rstmid_we_n got %b want 1", ram_we_n); end
    tests++; if (ram_ce_n !== 1'b1) begin fails++; $display("FAIL rstmid_ce_n got %b want 1", ram_ce_n); end
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL rstmid_ack got %b want 00", ack); end
    @(negedge clk);
    we = 2'b00; addr = {20'd5, 20'd3}; req = 2'b11;
    rst = 1'b1;
    m_ptr = 0; m_rd[0] = '0; m_rd[1] = '0;
    for (int n = 0; n < 40 && got.size() < 2; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (ack[k]) begin got.push_back(k); req[k] = 1'b0; end
    end
    req = 2'b00;
    @(negedge clk);
    m_rd[0] = m_mem[3]; m_rd[1] = m_mem[5]; m_ptr = 0;
    tests++; if (got.size() < 1 || got[0] != 0) begin fails++; $display("FAIL rstmid_first_grant got %0d want 0", got.size() ? got[0] : -1); end
    tests++; if (rdata !== {m_rd[1], m_rd[0]}) begin fails++; $display("FAIL rstmid_rdata got %h want %h", rdata, {m_rd[1], m_rd[0]}); end
  endtask

  task automatic test_random();
    logic [1:0]  mask;
    bit          w [2];
    logic [19:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  bn [2];
    int order[$], exp_order[$], start, first_lat, p, want_lat;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int it = 0; it < 25; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        w[k] = 1'($urandom_range(0, 1)); a[k] = 20'($urandom_range(0, 15));
        d[k] = $urandom; bn[k] = 4'($urandom);
        we[k] = w[k]; addr[k*20 +: 20] = a[k]; wdata[k*32 +: 32] = d[k]; be_n[k*4 +: 4] = bn[k];
      end
      exp_order.delete(); order.delete();
      for (int k = 0; k < 2; k++) begin p = (m_ptr + k) % 2; if (mask[p]) exp_order.push_back(p); end
      m_ptr = (exp_order[exp_order.size()-1] + 1) % 2;
      foreach (exp_order[j]) begin
        p = exp_order[j];
        if (w[p]) m_mem[a[p]] = merge(m_mem[a[p]], d[p], bn[p]);
        else      m_rd[p] = m_mem[a[p]];
      end
      want_lat = w[exp_order[0]] ? LW : LR;
      req = mask; start = cyc; first_lat = -1;
      for (int n = 0; n < 60 && order.size() < exp_order.size(); n++) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) if (ack[k]) begin
          order.push_back(k); req[k] = 1'b0;
          if (first_lat < 0) first_lat = cyc - start;
        end
      end
      req = 2'b00;
      @(negedge clk);
      tests++; if (order.size() != exp_order.size()) begin fails++; $display("FAIL rand_ack_count it%0d got %0d want %0d", it, order.size(), exp_order.size()); end
      foreach (exp_order[j]) begin
        tests++;
        if (j >= order.size() || order[j] != exp_order[j]) begin
          fails++; $display("FAIL rand_order it%0d[%0d] got %0d want %0d", it, j, (j < order.size()) ? order[j] : -1, exp_order[j]);
        end
      end
      tests++; if (first_lat != want_lat) begin fails++; $display("FAIL rand_latency it%0d got %0d want %0d", it, first_lat, want_lat); end
      tests++; if (rdata !== {m_rd[1], m_rd[0]}) begin fails++; $display("FAIL rand_rdata it%0d got %h want %h", it, rdata, {m_rd[1], m_rd[0]}); end
      for (int k = 0; k < 2; k++) if (mask[k] && w[k]) begin
        tests++;
        if (mem[a[k][5:0]] !== m_mem[a[k]]) begin fails++; $display("FAIL rand_mem it%0d addr %0d got %h want %h", it, a[k], mem[a[k][5:0]], m_mem[a[k]]); end
      end
    end
  endtask

  task automatic test_wait0();
    int start, lat, o0;
    for (int p = 0; p < 2; p++) begin
      val1 = $urandom;
      we1 = 2'b00; addr1[p*20 +: 20] = 20'h00044 + 20'(p);
      o0 = oe1_low; lat = -1;
      req1[p] = 1'b1; start = cyc;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (ack1[p]) begin lat = cyc - start; break; end
      end
      req1 = 2'b00;
      @(negedge clk);
      tests++; if (lat != 2) begin fails++; $display("FAIL wait0_latency p%0d got %0d want 2", p, lat); end
      tests++; if (oe1_low - o0 != 1) begin fails++; $display("FAIL wait0_oe_cycles p%0d got %0d want 1", p, oe1_low - o0); end
      tests++; if (rdata1[p*32 +: 32] !== val1) begin fails++; $display("FAIL wait0_rdata p%0d got %h want %h", p, rdata1[p*32 +: 32], val1); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; be_n = '0;
    req1 = '0; we1 = '0; addr1 = '0; wdata1 = '0; be_n1 = '0; val1 = '0;
    pre_addr = '0; pre_data = '0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_round_robin();
    test_drop_req();
    test_reset_mid_write();
    test_random();
    test_wait0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
